// File: rtl/if_id_pipe_reg_if.sv
// if_id_pipe_reg_if: bundle of the fetch-side inputs and decode-side outputs of the
// IF/ID pipeline register.
//
// Handshake: there is no ready signal. ValidIn/ValidOut mark whether the word in
// the same cycle is a real instruction; Stall is the only back-pressure and, when
// high, the register holds and the producer must hold its PC. Flush wins over
// Stall and replaces the held word with a bubble.
//
// Signals:
//   InstructionIn, PCPlus4In, ValidIn : fetch stage -> register
//   Stall, Flush                      : hazard unit -> register
//   InstructionOut, PCPlus4Out,
//   ValidOut, FlushedOut              : register -> decode stage
//   StallCycles, FlushCount,
//   InstrCount                        : performance counters (IFID_PERF_CNT_EN only)
// Modports: master = fetch/hazard side and decode consumer, slave = the register.
interface if_id_pipe_reg_if #(
  parameter int DATA_W = 32
);
  logic [DATA_W-1:0] InstructionIn;
  logic [DATA_W-1:0] PCPlus4In;
  logic              ValidIn;
  logic              Stall;
  logic              Flush;
  logic [DATA_W-1:0] InstructionOut;
  logic [DATA_W-1:0] PCPlus4Out;
  logic              ValidOut;
  logic              FlushedOut;
`ifdef IFID_PERF_CNT_EN
  logic [31:0]       StallCycles;
  logic [31:0]       FlushCount;
  logic [31:0]       InstrCount;

  modport master (
    output InstructionIn, PCPlus4In, ValidIn, Stall, Flush,
    input  InstructionOut, PCPlus4Out, ValidOut, FlushedOut,
    input  StallCycles, FlushCount, InstrCount
  );

  modport slave (
    input  InstructionIn, PCPlus4In, ValidIn, Stall, Flush,
    output InstructionOut, PCPlus4Out, ValidOut, FlushedOut,
    output StallCycles, FlushCount, InstrCount
  );
`else
  modport master (
    output InstructionIn, PCPlus4In, ValidIn, Stall, Flush,
    input  InstructionOut, PCPlus4Out, ValidOut, FlushedOut
  );

  modport slave (
    input  InstructionIn, PCPlus4In, ValidIn, Stall, Flush,
    output InstructionOut, PCPlus4Out, ValidOut, FlushedOut
  );
`endif
endinterface

// File: rtl/if_id_pipe_reg.sv
// if_id_pipe_reg: pipeline register between fetch and decode.
//
// Captures the fetched instruction and PC+4 each posedge Clk, holds them while the
// hazard unit stalls, and replaces them with a NOP bubble when a taken branch or
// jump flushes fetch. Priority per edge: Reset > Flush > Stall > load.
// All outputs are registered; there is no input-to-output combinational path.
//
// Ports:
//   Clk   : clock, all state updates on posedge
//   Reset : synchronous, active-high
//   bus   : if_id_pipe_reg_if slave modport (see interface header)
//
// Optional feature (macro IFID_PERF_CNT_EN): adds the wrapping 32-bit counters
// StallCycles, FlushCount and InstrCount. Without the macro these registers and
// ports do not exist.
module if_id_pipe_reg #(
  parameter int                DATA_W    = 32,
  parameter logic [DATA_W-1:0] NOP_INSTR = 32'h00000000
) (
  input  logic            Clk,
  input  logic            Reset,
  if_id_pipe_reg_if.slave bus
);

  // Initialisers give defined outputs in simulation before the first Reset.
  logic [DATA_W-1:0] instruction_q = NOP_INSTR;
  logic [DATA_W-1:0] pc_plus4_q    = '0;
  logic              valid_q       = 1'b0;
  logic              flushed_q     = 1'b0;
  logic [DATA_W-1:0] instruction_d;
  logic [DATA_W-1:0] pc_plus4_d;
  logic              valid_d;
  logic              flushed_d;

`ifdef IFID_PERF_CNT_EN
  logic [31:0] stall_cycles_q = '0;
  logic [31:0] flush_count_q  = '0;
  logic [31:0] instr_count_q  = '0;
  logic [31:0] stall_cycles_d;
  logic [31:0] flush_count_d;
  logic [31:0] instr_count_d;
`endif

  always_comb begin
    instruction_d = instruction_q;
    pc_plus4_d    = pc_plus4_q;
    valid_d       = valid_q;
    flushed_d     = 1'b0;
`ifdef IFID_PERF_CNT_EN
    stall_cycles_d = stall_cycles_q;
    flush_count_d  = flush_count_q;
    instr_count_d  = instr_count_q;
`endif
    if (Reset) begin
      instruction_d = NOP_INSTR;
      pc_plus4_d    = '0;
      valid_d       = 1'b0;
`ifdef IFID_PERF_CNT_EN
      stall_cycles_d = '0;
      flush_count_d  = '0;
      instr_count_d  = '0;
`endif
    end else if (bus.Flush) begin
      // PC+4 still advances so the debug trace keeps address continuity.
      instruction_d = NOP_INSTR;
      pc_plus4_d    = bus.PCPlus4In;
      valid_d       = 1'b0;
      flushed_d     = 1'b1;
`ifdef IFID_PERF_CNT_EN
      flush_count_d = flush_count_q + 32'd1;
`endif
    end else if (bus.Stall) begin
`ifdef IFID_PERF_CNT_EN
      stall_cycles_d = stall_cycles_q + 32'd1;
`endif
    end else begin
      // A non-valid word is captured as-is; decode keys off ValidOut.
      instruction_d = bus.InstructionIn;
      pc_plus4_d    = bus.PCPlus4In;
      valid_d       = bus.ValidIn;
`ifdef IFID_PERF_CNT_EN
      if (bus.ValidIn) instr_count_d = instr_count_q + 32'd1;
`endif
    end
  end

  always_ff @(posedge Clk) begin
    instruction_q <= instruction_d;
    pc_plus4_q    <= pc_plus4_d;
    valid_q       <= valid_d;
    flushed_q     <= flushed_d;
`ifdef IFID_PERF_CNT_EN
    stall_cycles_q <= stall_cycles_d;
    flush_count_q  <= flush_count_d;
    instr_count_q  <= instr_count_d;
`endif
  end

  assign bus.InstructionOut = instruction_q;
  assign bus.PCPlus4Out     = pc_plus4_q;
  assign bus.ValidOut       = valid_q;
  assign bus.FlushedOut     = flushed_q;
`ifdef IFID_PERF_CNT_EN
  assign bus.StallCycles = stall_cycles_q;
  assign bus.FlushCount  = flush_count_q;
  assign bus.InstrCount  = instr_count_q;
`endif

endmodule

// File: tb/tb_if_id_pipe_reg.sv
// tb_if_id_pipe_reg: directed plus random stimulus for if_id_pipe_reg. A reference
// model computes the expected register contents when inputs are driven; the result
// is queued and compared against the outputs after the following edge.
module tb_if_id_pipe_reg;
  localparam int DATA_W = 32;
  localparam int EXP_W  = 2 * DATA_W + 2;

  // ---------------- clock / reset ----------------
  logic clk   = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  if_id_pipe_reg_if #(.DATA_W(DATA_W)) bus ();

  if_id_pipe_reg #(
    .DATA_W   (DATA_W),
    .NOP_INSTR(32'h00000000)
  ) dut (
    .Clk  (clk),
    .Reset(reset),
    .bus  (bus.slave)
  );

  // ---------------- scoreboard ----------------
  logic [EXP_W-1:0] exp_q[$];
  int n_cmp = 0;
  int n_err = 0;

  // reference model state
  logic [DATA_W-1:0] m_instr   = 32'h00000000;
  logic [DATA_W-1:0] m_pc      = '0;
  logic              m_valid   = 1'b0;
  logic              m_flushed = 1'b0;
`ifdef IFID_PERF_CNT_EN
  logic [31:0] m_stall_cnt = '0;
  logic [31:0] m_flush_cnt = '0;
  logic [31:0] m_instr_cnt = '0;
`endif

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // ---------------- driver ----------------
  task automatic step(input string tag, input logic rst, input logic fl, input logic st,
                      input logic vin, input logic [31:0] ins, input logic [31:0] pc);
    logic [EXP_W-1:0] e;
    @(negedge clk);
    reset             = rst;
    bus.Flush         = fl;
    bus.Stall         = st;
    bus.ValidIn       = vin;
    bus.InstructionIn = ins;
    bus.PCPlus4In     = pc;
    // model: Reset > Flush > Stall > load
    if (rst) begin
      m_instr = 32'h00000000; m_pc = '0; m_valid = 1'b0; m_flushed = 1'b0;
`ifdef IFID_PERF_CNT_EN
      m_stall_cnt = '0; m_flush_cnt = '0; m_instr_cnt = '0;
`endif
    end else if (fl) begin
      m_instr = 32'h00000000; m_pc = pc; m_valid = 1'b0; m_flushed = 1'b1;
`ifdef IFID_PERF_CNT_EN
      m_flush_cnt++;
`endif
    end else if (st) begin
      m_flushed = 1'b0;
`ifdef IFID_PERF_CNT_EN
      m_stall_cnt++;
`endif
    end else begin
      m_instr = ins; m_pc = pc; m_valid = vin; m_flushed = 1'b0;
`ifdef IFID_PERF_CNT_EN
      if (vin) m_instr_cnt++;
`endif
    end
    exp_q.push_back({m_instr, m_pc, m_valid, m_flushed});
    @(posedge clk);
    #1;
    e = exp_q.pop_front();
    check({tag, ".instr"},   bus.InstructionOut,       e[EXP_W-1 -: DATA_W]);
    check({tag, ".pc4"},     bus.PCPlus4Out,           e[DATA_W+1 -: DATA_W]);
    check({tag, ".valid"},   {31'b0, bus.ValidOut},    {31'b0, e[1]});
    check({tag, ".flushed"}, {31'b0, bus.FlushedOut},  {31'b0, e[0]});
`ifdef IFID_PERF_CNT_EN
    check({tag, ".stall_cnt"}, bus.StallCycles, m_stall_cnt);
    check({tag, ".flush_cnt"}, bus.FlushCount,  m_flush_cnt);
    check({tag, ".instr_cnt"}, bus.InstrCount,  m_instr_cnt);
`endif
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    bus.InstructionIn = '0;
    bus.PCPlus4In     = '0;
    bus.ValidIn       = 1'b0;
    bus.Stall         = 1'b0;
    bus.Flush         = 1'b0;

    // outputs defined before any Reset
    #1;
    check("init.instr", bus.InstructionOut, 32'h00000000);
    check("init.pc4",   bus.PCPlus4Out,     32'h0);
    check("init.valid", {31'b0, bus.ValidOut}, 32'h0);

    // reset for two cycles with a live word on the input
    step("rst0", 1, 0, 0, 1, 32'h8C010004, 32'h4);
    step("rst1", 1, 0, 0, 1, 32'h8C010004, 32'h4);
    check("rst.instr_const", bus.InstructionOut, 32'h00000000);
    check("rst.valid_const", {31'b0, bus.ValidOut}, 32'h0);

    // load sequence, one edge latency
    step("ld0", 0, 0, 0, 1, 32'h20010005, 32'h4);
    check("ld0.instr_const", bus.InstructionOut, 32'h20010005);
    step("ld1", 0, 0, 0, 1, 32'h20020003, 32'h8);
    step("ld2", 0, 0, 0, 1, 32'h00221820, 32'hC);
    check("ld2.pc4_const", bus.PCPlus4Out, 32'hC);

    // put 0x20020003/8 back in the register, then stall 3 edges
    step("ld3", 0, 0, 0, 1, 32'h20020003, 32'h8);
    step("st0", 0, 0, 1, 1, 32'hAAAA0000, 32'h14);
    step("st1", 0, 0, 1, 1, 32'hAAAA0000, 32'h14);
    step("st2", 0, 0, 1, 1, 32'hAAAA0000, 32'h14);
    check("st2.instr_const", bus.InstructionOut, 32'h20020003);
    check("st2.pc4_const",   bus.PCPlus4Out,     32'h8);
    step("strel", 0, 0, 0, 1, 32'hAAAA0000, 32'h14);
    check("strel.instr_const", bus.InstructionOut, 32'hAAAA0000);

    // flush overrides stall; FlushedOut is a one-cycle pulse
    step("flst", 0, 1, 1, 1, 32'h1000FFFF, 32'h10);
    check("flst.instr_const",   bus.InstructionOut, 32'h00000000);
    check("flst.pc4_const",     bus.PCPlus4Out,     32'h10);
    check("flst.flushed_const", {31'b0, bus.FlushedOut}, 32'h1);
    step("flpost", 0, 0, 0, 1, 32'h20040001, 32'h14);
    check("flpost.flushed_const", {31'b0, bus.FlushedOut}, 32'h0);

    // back-to-back flushes
    step("fl2a", 0, 1, 0, 1, 32'h11112222, 32'h18);
    step("fl2b", 0, 1, 0, 1, 32'h33334444, 32'h1C);

    // invalid word captured as-is
    step("inv", 0, 0, 0, 0, 32'h12345678, 32'h20);
    check("inv.instr_const", bus.InstructionOut, 32'h12345678);

    // reset during a 2-cycle stall, then resume
    step("rs_ld", 0, 0, 0, 1, 32'hDEADBEEF, 32'h24);
    step("rs_st", 0, 0, 1, 1, 32'h0BADF00D, 32'h28);
    step("rs_rs", 1, 0, 1, 1, 32'h0BADF00D, 32'h28);
    step("rs_go", 0, 0, 0, 1, 32'h0BADF00D, 32'h28);

    // random mix
    for (int i = 0; i < 300; i++) begin
      step("rand", $urandom_range(0, 19) == 0, $urandom_range(0, 4) == 0,
           $urandom_range(0, 2) == 0, $urandom_range(0, 3) != 0,
           $urandom(), $urandom());
    end

`ifdef IFID_PERF_CNT_EN
    // 5 loads, 2 stalls, 1 flush from reset
    step("pc_rst", 1, 0, 0, 0, 32'h0, 32'h0);
    for (int i = 0; i < 5; i++) step("pc_ld", 0, 0, 0, 1, 32'h20000000 + i, 32'(4 * i + 4));
    step("pc_st0", 0, 0, 1, 1, 32'h0, 32'h0);
    step("pc_st1", 0, 0, 1, 1, 32'h0, 32'h0);
    step("pc_fl",  0, 1, 0, 1, 32'h0, 32'h18);
    check("pc.instr_cnt_const", bus.InstrCount,  32'd5);
    check("pc.stall_cnt_const", bus.StallCycles, 32'd2);
    check("pc.flush_cnt_const", bus.FlushCount,  32'd1);

    // wrap of the stall counter
    @(negedge clk);
    force dut.stall_cycles_q = 32'hFFFFFFFF;
    #1;
    release dut.stall_cycles_q;
    m_stall_cnt = 32'hFFFFFFFF;
    step("pc_wrap", 0, 0, 1, 1, 32'h0, 32'h0);
    check("pc.wrap_const", bus.StallCycles, 32'h0);
`endif

    // ---------------- report ----------------
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/if_id_pipe_reg.md
Name: if_id_pipe_reg

Overview:
- Pipeline register between the fetch stage and the decode stage.
- Captures the fetched instruction and PC+4 on the rising edge of Clk.
- Holds its contents when the hazard unit stalls.
- Squashes its contents to a NOP bubble when a taken branch or jump flushes fetch.

Parameters:
DATA_W, 32, width of the instruction and PC fields
NOP_INSTR, 32'h00000000, instruction word inserted on flush or reset (sll $0,$0,0)

Ports:
Clk  in  1  clock; all state updates on posedge
Reset  in  1  synchronous active-high reset
InstructionIn  in  DATA_W  word from instruction memory for the current PC
PCPlus4In  in  DATA_W  PCResult+4 from the fetch adder
ValidIn  in  1  fetch produced a real instruction this cycle
Stall  in  1  hold current contents (load-use hazard)
Flush  in  1  discard current contents; insert bubble
InstructionOut  out  DATA_W  registered instruction to decode
PCPlus4Out  out  DATA_W  registered PC+4 to decode and branch-target adder
ValidOut  out  1  registered instruction is real (not a bubble)
FlushedOut  out  1  one-cycle pulse: bubble inserted by flush in the previous edge

Behaviour:
- Reset and clock: Reset is synchronous, active-high; clock is Clk. Sampled only at posedge Clk.
- Reset values: InstructionOut=NOP_INSTR, PCPlus4Out=0, ValidOut=0, FlushedOut=0. All registers are also initialised to these values for simulation, so no output is X before the first Reset.
- Priority at each posedge: Reset > Flush > Stall > load.
- Load (Reset=0, Flush=0, Stall=0):
  - InstructionOut<=InstructionIn, PCPlus4Out<=PCPlus4In, ValidOut<=ValidIn, FlushedOut<=0.
  - Latency is exactly 1 cycle from input to output.
- Stall (Reset=0, Flush=0, Stall=1):
  - All data outputs and ValidOut hold their previous values; FlushedOut<=0.
  - Stall for N consecutive cycles holds for N cycles. The first non-stall edge loads the then-current inputs. Upstream must hold its PC during stall; this block performs no replay.
- Flush (Reset=0, Flush=1):
  - InstructionOut<=NOP_INSTR, ValidOut<=0, FlushedOut<=1.
  - PCPlus4Out<=PCPlus4In, so the debug trace keeps address continuity.
  - Flush overrides a simultaneous Stall: a mispredicted-path instruction is never held.
- Back-to-back Flush: produces consecutive bubbles; FlushedOut stays 1 for each flushed edge.
- ValidIn=0 with load: the word is captured as-is, ValidOut=0. Decode must treat it as a bubble; no substitution with NOP_INSTR.
- Reset mid-stall or mid-flush: Reset wins; the next edge with Reset=0 follows normal priority.
- No combinational path from any input to any output; all outputs are registered.
- Widths: DATA_W bits throughout; PCPlus4 is not recomputed here (no arithmetic, no wrap handling).

Optional Feature:
- Macro IFID_PERF_CNT_EN. When defined, adds three outputs:
  - StallCycles[31:0]: increments on each edge with Stall=1, Flush=0, Reset=0.
  - FlushCount[31:0]: increments on each edge with Flush=1, Reset=0.
  - InstrCount[31:0]: increments on each edge with a load where ValidIn=1.
- All three counters reset to 0 on Reset and wrap modulo 2^32 (0xFFFFFFFF+1 -> 0).
- When not defined, these ports and registers do not exist and all other behaviour is identical.

Test Plan:
- Reset=1 for 2 cycles with InstructionIn=0x8C010004 -> InstructionOut=0x00000000, PCPlus4Out=0, ValidOut=0, FlushedOut=0.
- Load sequence PCPlus4In=4,8,12 with instructions 0x20010005, 0x20020003, 0x00221820, ValidIn=1 -> outputs match each input exactly one edge later, ValidOut=1.
- Hold InstructionOut=0x20020003/PCPlus4Out=8, assert Stall 3 cycles while inputs change to 0xAAAA0000 -> outputs unchanged for 3 edges; first edge after release captures current input.
- Flush=1 and Stall=1 on the same edge with InstructionIn=0x1000FFFF, PCPlus4In=0x10 -> InstructionOut=0x00000000, ValidOut=0, PCPlus4Out=0x10, FlushedOut=1 for exactly one cycle.
- Assert Reset during a 2-cycle stall -> outputs go to reset values on that edge; normal loading resumes on the next edge after Reset deasserts.
- With IFID_PERF_CNT_EN: 5 loads, 2 stalls, 1 flush from reset -> InstrCount=5, StallCycles=2, FlushCount=1. Force StallCycles=0xFFFFFFFF, then 1 stall -> StallCycles=0.
